// File: rtl/kt_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package kt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX     = 59;
  localparam int MAX_MIN_DEF = 99;

endpackage

// File: rtl/mmss_bcd_counter.sv
// Four-digit BCD mm:ss register with increment, decrement-with-borrow and clear controls.
module mmss_bcd_counter
  import kt_pkg::*;
#(
  parameter int MAX_MIN = MAX_MIN_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_zero_i,
  input  logic       dec_i,
  input  logic       inc_min_i,
  input  logic       inc_sec_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       is_zero_o
);

  localparam bcd_t SEC_TENS_MAX = 4'(SEC_MAX / 10);
  localparam bcd_t MIN_TENS_MAX = 4'(MAX_MIN / 10);
  localparam bcd_t MIN_ONES_MAX = 4'(MAX_MIN % 10);

  bcd_t min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  bcd_t min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;

  assign is_zero_o = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                     (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (load_zero_i) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (dec_i) begin
      // Decrementing 00:00 is never requested; hold it there if it ever is.
      if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else if (sec_tens_q != 4'd0) begin
        sec_ones_d = 4'd9;
        sec_tens_d = sec_tens_q - 4'd1;
      end else if (min_ones_q != 4'd0) begin
        sec_ones_d = 4'd9;
        sec_tens_d = SEC_TENS_MAX;
        min_ones_d = min_ones_q - 4'd1;
      end else if (min_tens_q != 4'd0) begin
        sec_ones_d = 4'd9;
        sec_tens_d = SEC_TENS_MAX;
        min_ones_d = 4'd9;
        min_tens_d = min_tens_q - 4'd1;
      end
    end else begin
      if (inc_sec_i) begin
        if (sec_ones_q == 4'd9) begin
          sec_ones_d = 4'd0;
          sec_tens_d = (sec_tens_q == SEC_TENS_MAX) ? 4'd0 : sec_tens_q + 4'd1;
        end else begin
          sec_ones_d = sec_ones_q + 4'd1;
        end
      end
      if (inc_min_i) begin
        if ((min_tens_q == MIN_TENS_MAX) && (min_ones_q == MIN_ONES_MAX)) begin
          min_tens_d = 4'd0;
          min_ones_d = 4'd0;
        end else if (min_ones_q == 4'd9) begin
          min_ones_d = 4'd0;
          min_tens_d = min_tens_q + 4'd1;
        end else begin
          min_ones_d = min_ones_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
    end
  end

  assign min_tens_o = min_tens_q;
  assign min_ones_o = min_ones_q;
  assign sec_tens_o = sec_tens_q;
  assign sec_ones_o = sec_ones_q;

endmodule

// File: rtl/countdown_core.sv
// Countdown timer control: IDLE/RUN/PAUSE/ALARM FSM, alarm duration counter, mm:ss digits.
module countdown_core
  import kt_pkg::*;
#(
  parameter int ALARM_TICKS = 10,
  parameter int MAX_MIN     = MAX_MIN_DEF
) (
  input  logic       in_clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state_o
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_e     state_q;
  logic       running_q, alarm_q;
  logic [7:0] alarm_cnt_q;

  logic cnt_load_zero, cnt_dec, cnt_inc_min, cnt_inc_sec;
  logic is_zero, is_one;

  assign is_one = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd1);

  // Digit controls follow the same priority as the FSM: clear, start_stop, sec_tick, increments.
  always_comb begin
    cnt_load_zero = 1'b0;
    cnt_dec       = 1'b0;
    cnt_inc_min   = 1'b0;
    cnt_inc_sec   = 1'b0;
    if (clear) begin
      cnt_load_zero = 1'b1;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          cnt_inc_min = inc_min && !start_stop;
          cnt_inc_sec = inc_sec && !start_stop;
        end
        RUN:     cnt_dec = sec_tick && !start_stop;
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= 8'd0;
    end else if (clear) begin
      state_q     <= IDLE;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (start_stop && !is_zero) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (sec_tick && is_one) begin
            state_q     <= ALARM;
            running_q   <= 1'b0;
            alarm_q     <= 1'b1;
            alarm_cnt_q <= 8'd0;
          end
        end
        ALARM: begin
          if (start_stop || (sec_tick && (alarm_cnt_q == ALARM_LAST))) begin
            state_q     <= IDLE;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= 8'd0;
          end else if (sec_tick) begin
            alarm_cnt_q <= alarm_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mmss_bcd_counter #(
    .MAX_MIN(MAX_MIN)
  ) u_digits (
    .clk_i       (in_clk),
    .rst_ni      (rst_n),
    .load_zero_i (cnt_load_zero),
    .dec_i       (cnt_dec),
    .inc_min_i   (cnt_inc_min),
    .inc_sec_i   (cnt_inc_sec),
    .min_tens_o  (min_tens),
    .min_ones_o  (min_ones),
    .sec_tens_o  (sec_tens),
    .sec_ones_o  (sec_ones),
    .is_zero_o   (is_zero)
  );

  assign running = running_q;
  assign alarm   = alarm_q;
  assign state_o = state_q;

endmodule
